// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, read-owner
// tags, default fairness limits and a counter width helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CPU_OWN    = 2'd1,
        ST_HOST_OWN   = 2'd2,
        ST_HOST_BURST = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_HOST = 2'd2
    } owner_tag_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_BURST_MAX    = 16;

    // Bits needed to hold the values 0..max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester port (CPU or host side) and memory port bundles for dmem_arbiter.
// master = the side that issues requests / drives the memory.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     req;
    logic                     we;
    logic                     byte_en;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     gnt;
    logic                     stall;
    logic                     rvalid;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output req, we, byte_en, addr, wdata,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, we, byte_en, addr, wdata,
        output gnt, stall, rvalid, rdata
    );
endinterface

interface dmem_mem_if #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     en;
    logic                     we;
    logic                     byte_en;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output en, we, byte_en, addr, wdata,
        input  rdata
    );

    modport slave (
        input  en, we, byte_en, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment
// loads 1 so a new run can start in the same cycle the old one ends.
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX   = 15,
    parameter int WIDTH = cnt_width(MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_reg != MAX_VAL)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == MAX_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU priority with host anti-starvation,
// locked host bursts with a forced CPU slot, and tagged read-return routing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT,
    parameter int BURST_MAX     = DEFAULT_BURST_MAX
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  cpu,
    dmem_arbiter_if.slave  host,
    input  logic           host_lock,
    dmem_mem_if.master     mem
);

    localparam int STARVE_W = cnt_width(STARVE_LIMIT);
    localparam int BURST_W  = cnt_width(BURST_MAX);

    arb_state_t state_reg, state_next;
    owner_tag_t tag_reg, tag_next;
    logic       yield_reg, yield_next;

    logic [DATA_WIDTH-1:0]    cpu_rdata_reg;
    logic [DATA_WIDTH-1:0]    host_rdata_reg;
    logic [ADDRESS_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0]    grant_wdata;

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;
    logic [BURST_W-1:0]  burst_cnt;
    logic                burst_full;

    logic cpu_gnt, host_gnt, forced_yield;
    logic contested, locked_host, burst_hold;
    logic cpu_rvalid, host_rvalid;
    logic burst_inc, burst_clr;

    assign contested   = cpu.req && host.req;
    assign locked_host = host.req && host_lock;
    assign burst_hold  = (state_reg == ST_HOST_BURST) && locked_host;

    always_comb begin
        cpu_gnt      = 1'b0;
        host_gnt     = 1'b0;
        forced_yield = 1'b0;
        state_next   = ST_IDLE;
        tag_next     = TAG_NONE;

        if (burst_hold) begin
            // A full burst yields exactly one slot to a waiting CPU.
            if (burst_full && cpu.req) begin
                cpu_gnt      = 1'b1;
                forced_yield = 1'b1;
            end else begin
                host_gnt = 1'b1;
            end
        end else if (yield_reg && locked_host) begin
            host_gnt = 1'b1;
        end else if (contested) begin
            if (starve_hit) begin
                host_gnt = 1'b1;
            end else begin
                cpu_gnt = 1'b1;
            end
        end else if (cpu.req) begin
            cpu_gnt = 1'b1;
        end else if (host.req) begin
            host_gnt = 1'b1;
        end

        if (rst) begin
            cpu_gnt      = 1'b0;
            host_gnt     = 1'b0;
            forced_yield = 1'b0;
        end

        if (host_gnt) begin
            state_next = host_lock ? ST_HOST_BURST : ST_HOST_OWN;
        end else if (cpu_gnt) begin
            state_next = ST_CPU_OWN;
        end

        if (cpu_gnt && !cpu.we) begin
            tag_next = TAG_CPU;
        end else if (host_gnt && !host.we) begin
            tag_next = TAG_HOST;
        end

        yield_next = forced_yield;
    end

    assign burst_inc = host_gnt && host_lock;
    assign burst_clr = !burst_inc || burst_full;

    sat_counter #(.MAX(STARVE_LIMIT), .WIDTH(STARVE_W)) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (host_gnt),
        .inc    (host.req && !host_gnt),
        .count  (starve_cnt),
        .at_max (starve_hit)
    );

    sat_counter #(.MAX(BURST_MAX), .WIDTH(BURST_W)) u_burst_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (burst_clr),
        .inc    (burst_inc),
        .count  (burst_cnt),
        .at_max (burst_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tag_reg        <= TAG_NONE;
            yield_reg      <= 1'b0;
            cpu_rdata_reg  <= '0;
            host_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            yield_reg <= yield_next;
            if (tag_reg == TAG_CPU) begin
                cpu_rdata_reg <= mem.rdata;
            end
            if (tag_reg == TAG_HOST) begin
                host_rdata_reg <= mem.rdata;
            end
        end
    end

    // Returned data passes straight through on its rvalid cycle and is held after.
    assign cpu_rvalid  = (tag_reg == TAG_CPU);
    assign host_rvalid = (tag_reg == TAG_HOST);

    assign cpu.gnt    = cpu_gnt;
    assign cpu.stall  = cpu.req && !cpu_gnt;
    assign cpu.rvalid = cpu_rvalid;
    assign cpu.rdata  = cpu_rvalid ? mem.rdata : cpu_rdata_reg;

    assign host.gnt    = host_gnt;
    assign host.stall  = host.req && !host_gnt;
    assign host.rvalid = host_rvalid;
    assign host.rdata  = host_rvalid ? mem.rdata : host_rdata_reg;

    assign grant_addr  = host_gnt ? host.addr  : cpu.addr;
    assign grant_wdata = host_gnt ? host.wdata : cpu.wdata;

    assign mem.en      = cpu_gnt || host_gnt;
    assign mem.we      = host_gnt ? host.we      : (cpu_gnt && cpu.we);
    assign mem.byte_en = host_gnt ? host.byte_en : (cpu_gnt && cpu.byte_en);
    assign mem.addr    = grant_addr;
    assign mem.wdata   = grant_wdata;

    a_one_grant: assert property (@(posedge clk) disable iff (rst) !(cpu_gnt && host_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a policy-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW   = 20;
    localparam int AW   = 8;
    localparam int SL   = 4;
    localparam int BM   = 16;
    localparam int BUSW = 2*DW + 2 + AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_lock = 1'b0;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) cpu ();
    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) host ();
    dmem_mem_if     #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) mem ();

    dmem_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(SL), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .rst(rst), .cpu(cpu), .host(host), .host_lock(host_lock), .mem(mem)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 16) return 20'h0ABCD;
        return DW'(a * 32'h1357 + 32'h2468);
    endfunction

    // Synchronous-read memory attached to the arbiter.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
        end else if (mem.en) begin
            if (mem.we) ram[mem.addr] <= mem.byte_en ? {ram[mem.addr][DW-1:8], mem.wdata[7:0]} : mem.wdata;
            else        ram_q <= ram[mem.addr];
        end
    end
    assign mem.rdata = ram_q;

    // Reference model: policy state in plain integers and a shadow memory.
    int            host_wait, burst_len, pend_owner;
    bit            in_burst, yield_due, e_cg, e_hg;
    logic [DW-1:0] pend_data, cpu_last, host_last;
    logic [DW-1:0] shadow [0:255];
    int            vectors = 0;
    int            miscompares = 0;

    task automatic model_reset();
        host_wait = 0; burst_len = 0; in_burst = 0; yield_due = 0;
        pend_owner = 0; pend_data = '0; cpu_last = '0; host_last = '0;
        e_cg = 0; e_hg = 0;
    endtask

    task automatic predict();
        bit lock_run;
        lock_run = host.req && host_lock;
        e_cg = 0; e_hg = 0;
        if (rst) begin
            e_cg = 0;
        end else if (lock_run && (in_burst || yield_due)) begin
            if (in_burst && burst_len >= BM && cpu.req) e_cg = 1;
            else e_hg = 1;
        end else if (cpu.req && host.req) begin
            if (host_wait >= SL) e_hg = 1; else e_cg = 1;
        end else begin
            e_cg = cpu.req; e_hg = host.req;
        end
    endtask

    task automatic shadow_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic be);
        if (be) shadow[a] = {shadow[a][DW-1:8], d[7:0]};
        else    shadow[a] = d;
    endtask

    task automatic commit();
        if (rst) begin
            model_reset();
            return;
        end
        if (pend_owner == 1) cpu_last = pend_data;
        if (pend_owner == 2) host_last = pend_data;
        pend_owner = 0;
        if (e_cg) begin
            if (cpu.we) shadow_write(cpu.addr, cpu.wdata, cpu.byte_en);
            else begin pend_owner = 1; pend_data = shadow[cpu.addr]; end
        end
        if (e_hg) begin
            if (host.we) shadow_write(host.addr, host.wdata, host.byte_en);
            else begin pend_owner = 2; pend_data = shadow[host.addr]; end
        end
        yield_due = e_cg && in_burst && burst_len >= BM && host.req && host_lock;
        if (e_hg && host_lock) begin
            burst_len = (in_burst && burst_len >= BM) ? 1 : burst_len + 1;
            in_burst  = 1;
        end else begin
            burst_len = 0;
            in_burst  = 0;
        end
        host_wait = e_hg ? 0 : host_wait + (host.req ? 1 : 0);
    endtask

    function automatic logic [6:0] obs_ctl();
        return {cpu.gnt, host.gnt, cpu.stall, host.stall, mem.en, cpu.rvalid, host.rvalid};
    endfunction

    function automatic logic [6:0] exp_ctl();
        return {e_cg, e_hg, cpu.req & ~e_cg, host.req & ~e_hg, e_cg | e_hg,
                pend_owner == 1, pend_owner == 2};
    endfunction

    function automatic logic [BUSW-1:0] obs_bus();
        return {cpu.rdata, host.rdata,
                (e_cg | e_hg) ? {mem.we, mem.byte_en, mem.addr, mem.wdata} : {(2+AW+DW){1'b0}}};
    endfunction

    function automatic logic [BUSW-1:0] exp_bus();
        logic [2+AW+DW-1:0] m;
        m = '0;
        if (e_hg)      m = {host.we, host.byte_en, host.addr, host.wdata};
        else if (e_cg) m = {cpu.we, cpu.byte_en, cpu.addr, cpu.wdata};
        return {(pend_owner == 1) ? pend_data : cpu_last,
                (pend_owner == 2) ? pend_data : host_last, m};
    endfunction

    task automatic set_cpu(input logic r, input logic w, input logic b,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu.req = r; cpu.we = w; cpu.byte_en = b; cpu.addr = a; cpu.wdata = d;
    endtask

    task automatic set_host(input logic r, input logic w, input logic b, input logic l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        host.req = r; host.we = w; host.byte_en = b; host_lock = l; host.addr = a; host.wdata = d;
    endtask

    task automatic test_reset();
        set_cpu(1, 0, 0, 8'h10, '0);
        set_host(1, 0, 0, 1, 8'h02, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL reset_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL reset_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            @(posedge clk); commit(); #1;
            preload = 1'b0;
        end
        rst = 1'b0;
        set_cpu(0, 0, 0, '0, '0);
        set_host(0, 0, 0, 0, '0, '0);
    endtask

    task automatic test_solo_read();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_cpu(1, 0, 0, 8'h10, '0); else set_cpu(0, 0, 0, '0, '0);
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL solo_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL solo_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            vectors++;
            if (i == 0 && cpu.gnt !== 1'b1) begin miscompares++;
                $display("FAIL solo_gnt got %b want 1", cpu.gnt); end
            if (i == 1 && {cpu.rvalid, host.rvalid, cpu.rdata} !== {1'b1, 1'b0, 20'h0ABCD}) begin miscompares++;
                $display("FAIL solo_rdata got %b%b %h want 10 0abcd", cpu.rvalid, host.rvalid, cpu.rdata); end
            @(posedge clk); commit(); #1;
        end
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 9; i++) begin
            set_cpu(i < 8 && i % 2 == 0, 0, 0, 8'h01, '0);
            set_host(i < 8 && i % 2 == 1, 0, 0, 0, 8'h02, '0);
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL alt_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL alt_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            if (i > 0) begin
                vectors++;
                if ((i % 2 == 1) ? ({cpu.rvalid, host.rvalid, cpu.rdata} !== {2'b10, init_word(1)})
                                 : ({cpu.rvalid, host.rvalid, host.rdata} !== {2'b01, init_word(2)})) begin
                    miscompares++;
                    $display("FAIL alt_route cyc %0d got rv %b%b c %h h %h", i, cpu.rvalid, host.rvalid,
                             cpu.rdata, host.rdata);
                end
            end
            @(posedge clk); commit(); #1;
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 16; i++) begin
            set_cpu(i < 15, 0, 0, AW'(i), '0);
            set_host(i < 15, 0, 0, 0, AW'(8'h40 + i), '0);
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL starve_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL starve_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            if (i < 15) begin
                vectors++;
                if ({host.gnt, cpu.stall} !== {2{i % 5 == 4}}) begin miscompares++;
                    $display("FAIL starve_pattern cyc %0d got gnt %b stall %b want %b", i, host.gnt,
                             cpu.stall, i % 5 == 4); end
            end
            @(posedge clk); commit(); #1;
        end
    endtask

    task automatic test_burst();
        int host_cnt;
        int i;
        host_cnt = 0;
        for (i = 0; i < 40 && host_cnt < 20; i++) begin
            set_host(1, 1, 0, 1, AW'(8'h80 + host_cnt), DW'($urandom));
            set_cpu(i > 0, 0, 0, 8'h20, '0);
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL burst_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL burst_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            vectors++;
            if ({host.gnt, cpu.gnt} !== {i != 16, i == 16}) begin miscompares++;
                $display("FAIL burst_seq cyc %0d got h%b c%b want h%b c%b", i, host.gnt, cpu.gnt,
                         i != 16, i == 16); end
            @(posedge clk);
            if (e_hg) host_cnt++;
            commit(); #1;
        end
        vectors++;
        if (host_cnt != 20 || i != 21) begin miscompares++;
            $display("FAIL burst_len got %0d grants in %0d cycles want 20 in 21", host_cnt, i); end
        set_cpu(0, 0, 0, '0, '0);
        set_host(0, 0, 0, 0, '0, '0);
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 5; i++) begin
            set_host(1, 0, 0, 1, AW'(8'h30 + i), '0);
            set_cpu(0, 0, 0, '0, '0);
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL rstb_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL rstb_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            @(posedge clk); commit(); #1;
        end
        #1 rst = 1'b1;
        model_reset();
        #1 predict();
        vectors++;
        if ({cpu.gnt, host.gnt, mem.en, cpu.rvalid, host.rvalid, host.rdata} !== {5'b0, {DW{1'b0}}}) begin
            miscompares++;
            $display("FAIL rstb_immediate got %b%b%b%b%b %h want 00000 0", cpu.gnt, host.gnt, mem.en,
                     cpu.rvalid, host.rvalid, host.rdata);
        end
        set_cpu(1, 0, 0, 8'h10, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL rstb_hold_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL rstb_hold_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            @(posedge clk); commit(); #1;
        end
        vectors++;
        if (dut.state_reg !== ST_IDLE) begin miscompares++;
            $display("FAIL rstb_state got %0d want %0d", dut.state_reg, ST_IDLE); end
        rst = 1'b0;
        set_host(0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) set_cpu(0, 0, 0, '0, '0);
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL rstb_rel_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL rstb_rel_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            vectors++;
            if (i == 0 && {cpu.gnt, host.rvalid} !== 2'b10) begin miscompares++;
                $display("FAIL rstb_release got gnt %b hrv %b want 1 0", cpu.gnt, host.rvalid); end
            if (i == 1 && {cpu.rvalid, host.rvalid, cpu.rdata} !== {2'b10, 20'h0ABCD}) begin miscompares++;
                $display("FAIL rstb_read got %b%b %h want 10 0abcd", cpu.rvalid, host.rvalid, cpu.rdata); end
            @(posedge clk); commit(); #1;
        end
    endtask

    task automatic test_idle();
        set_cpu(0, 0, 0, '0, '0);
        set_host(0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL idle_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            if (i > 0) begin
                vectors++;
                if ({mem.en, dut.state_reg, dut.starve_cnt, dut.burst_cnt} !== '0) begin miscompares++;
                    $display("FAIL idle_state cyc %0d got en %b st %0d sc %0d bc %0d want all 0", i,
                             mem.en, dut.state_reg, dut.starve_cnt, dut.burst_cnt); end
            end
            @(posedge clk); commit(); #1;
        end
    endtask

    task automatic test_random();
        bit h_on, lock_on;
        h_on = 0; lock_on = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0)  h_on = !h_on;
            if ($urandom_range(0, 24) == 0) lock_on = !lock_on;
            set_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), DW'($urandom));
            set_host(h_on, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                     lock_on && ($urandom_range(0, 15) != 0), AW'($urandom_range(0, 15)), DW'($urandom));
            @(negedge clk); predict();
            vectors++;
            if (obs_ctl() !== exp_ctl()) begin miscompares++;
                $display("FAIL rand_ctl cyc %0d got %b want %b", i, obs_ctl(), exp_ctl()); end
            vectors++;
            if (obs_bus() !== exp_bus()) begin miscompares++;
                $display("FAIL rand_bus cyc %0d got %h want %h", i, obs_bus(), exp_bus()); end
            @(posedge clk); commit(); #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
        model_reset();
        set_cpu(0, 0, 0, '0, '0);
        set_host(0, 0, 0, 0, '0, '0);
        test_reset();
        test_solo_read();
        test_alternating();
        test_starvation();
        test_burst();
        test_reset_midburst();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
